// File: rtl/wb_pkg.sv
// Shared widths and FSM state encoding for the Wishbone classic initiator.
package wb_pkg;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;
endpackage

// File: rtl/wb_initiator_if.sv
// Local command/response channel plus Wishbone classic master signals.
// Handshake: a command transfers on any rising edge where req_valid && req_ready.
interface wb_initiator_if;
    import wb_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [WB_ADDR_W-1:0] req_adr;
    logic [WB_DATA_W-1:0] req_dat;
    logic [WB_SEL_W-1:0]  req_sel;

    logic                 resp_valid;
    logic [WB_DATA_W-1:0] resp_rdata;
    logic                 resp_err;

    logic                 wbm_cyc_o;
    logic                 wbm_stb_o;
    logic                 wbm_we_o;
    logic [WB_ADDR_W-1:0] wbm_adr_o;
    logic [WB_DATA_W-1:0] wbm_dat_o;
    logic [WB_SEL_W-1:0]  wbm_sel_o;
    logic                 wbm_ack_i;
    logic [WB_DATA_W-1:0] wbm_dat_i;

    modport master (
        input  req_valid, req_we, req_adr, req_dat, req_sel,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output req_valid, req_we, req_adr, req_dat, req_sel,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_timeout_counter.sv
// Counts bus-phase cycles without ack; expired_o flags the LIMIT-th such cycle.
module wb_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt_q, cnt_d;

    // cnt_q holds how many bus cycles already passed, so the current cycle is cnt_q+1.
    assign expired_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: IDLE -> BUS -> RESP.
// Optional bus timeout abort enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_initiator_if.master    bus,
    output wb_state_e         state_o
);
    wb_state_e state_q, state_d;

    logic accept, ack_done, timeout;
    logic we_q;
    logic [WB_ADDR_W-1:0] adr_q;
    logic [WB_DATA_W-1:0] dat_q, rdata_q;
    logic [WB_SEL_W-1:0]  sel_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) state_d = ST_BUS;
            ST_BUS:  if (bus.wbm_ack_i || timeout) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.wbm_cyc_o  = (state_q == ST_BUS);
        bus.wbm_stb_o  = (state_q == ST_BUS);
        bus.resp_valid = (state_q == ST_RESP);
        accept         = (state_q == ST_IDLE) && bus.req_valid;
        ack_done       = (state_q == ST_BUS) && bus.wbm_ack_i;
    end

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic expired, err_q;

    wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (accept),
        .enable_i  ((state_q == ST_BUS) && !bus.wbm_ack_i),
        .expired_o (expired)
    );

    // Ack in the expiring cycle wins because expired only counts no-ack cycles.
    assign timeout = expired;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_q <= 1'b0;
        end else if (ack_done) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end
    assign bus.resp_err = err_q;
`else
    assign timeout      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // Bus attributes load only on acceptance, so they hold through BUS and after.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (accept) begin
            we_q  <= bus.req_we;
            adr_q <= bus.req_adr;
            dat_q <= bus.req_dat;
            sel_q <= bus.req_sel;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rdata_q <= '0;
        end else if (ack_done) begin
            rdata_q <= we_q ? '0 : bus.wbm_dat_i;
        end else if (timeout) begin
            rdata_q <= '0;
        end
    end

    assign bus.wbm_we_o   = we_q;
    assign bus.wbm_adr_o  = adr_q;
    assign bus.wbm_dat_o  = dat_q;
    assign bus.wbm_sel_o  = sel_q;
    assign bus.resp_rdata = rdata_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_wb_initiator.sv
// Directed and randomized bench for wb_initiator with a transaction-level model.
module tb_wb_initiator;
    import wb_pkg::*;

    localparam int unsigned TO = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic      clk;
    logic      rst;
    wb_state_e state;
    int        checks;
    int        errors;
    logic [32:0] exp_q[$];

    wb_initiator_if bif();

    wb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bif.master),
        .state_o  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: ack arrives in bus cycle waits+1 unless the timeout ends the cycle first.
    function automatic int model_cycles(input int waits);
        if (TO_EN && (waits + 1 > int'(TO))) return int'(TO);
        return waits + 1;
    endfunction

    function automatic logic [32:0] model_resp(input logic we, input int waits,
                                               input logic [31:0] rdata);
        if (TO_EN && (waits + 1 > int'(TO))) return {1'b1, 32'h0};
        return {1'b0, we ? 32'h0 : rdata};
    endfunction

    task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int waits, input logic [31:0] rdata);
        int k;
        int exp_cyc;
        logic [32:0] exp;
        logic stable;
        exp_cyc = model_cycles(waits);
        exp_q.push_back(model_resp(we, waits, rdata));
        bif.req_valid = 1'b1;
        bif.req_we = we;
        bif.req_adr = adr;
        bif.req_dat = dat;
        bif.req_sel = sel;
        step();
        bif.req_valid = 1'b0;
        bif.req_we = ~we;
        bif.req_adr = $urandom;
        bif.req_dat = $urandom;
        bif.req_sel = 4'($urandom);
        chk({tag, " cyc"}, 64'(bif.wbm_cyc_o), 64'd1);
        chk({tag, " stb"}, 64'(bif.wbm_stb_o), 64'd1);
        chk({tag, " bus"}, {bif.wbm_we_o, bif.wbm_sel_o, bif.wbm_adr_o},
            {we, sel, adr});
        chk({tag, " wdat"}, 64'(bif.wbm_dat_o), 64'(dat));
        k = 1;
        stable = 1'b1;
        while (1) begin
            bif.wbm_ack_i = (k == waits + 1);
            bif.wbm_dat_i = (k == waits + 1) ? rdata : $urandom;
            step();
            bif.wbm_ack_i = 1'b0;
            if (bif.resp_valid) break;
            if (!bif.wbm_cyc_o || bif.wbm_adr_o != adr || bif.wbm_dat_o != dat ||
                bif.wbm_sel_o != sel || bif.wbm_we_o != we) stable = 1'b0;
            k++;
            if (k > 1100) break;
        end
        chk({tag, " hold"}, 64'(stable), 64'd1);
        chk({tag, " cycles"}, 64'(k), 64'(exp_cyc));
        exp = exp_q.pop_front();
        chk({tag, " resp"}, {bif.resp_valid, bif.resp_err, bif.resp_rdata},
            {1'b1, exp});
        chk({tag, " cyc_off"}, {bif.wbm_cyc_o, bif.wbm_stb_o}, 64'd0);
        step();
        chk({tag, " pulse"}, 64'(bif.resp_valid), 64'd0);
        chk({tag, " ready"}, 64'(bif.req_ready), 64'd1);
        chk({tag, " keep"}, {bif.wbm_stb_o, bif.wbm_adr_o}, {1'b0, adr});
    endtask

    initial begin
        logic bad;
        logic [32:0] exp;
        logic [31:0] d;
        checks = 0;
        errors = 0;
        bif.req_valid = 1'b0;
        bif.req_we = 1'b0;
        bif.req_adr = '0;
        bif.req_dat = '0;
        bif.req_sel = '0;
        bif.wbm_ack_i = 1'b0;
        bif.wbm_dat_i = '0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst ctrl", {bif.wbm_cyc_o, bif.wbm_stb_o, bif.wbm_we_o, bif.resp_valid,
                         bif.resp_err}, 64'd0);
        chk("rst data", {bif.wbm_adr_o, bif.wbm_dat_o}, 64'd0);
        chk("rst sel/rdata", {bif.wbm_sel_o, bif.resp_rdata}, 64'd0);
        rst = 1'b0;
        step();
        chk("rst ready", 64'(bif.req_ready), 64'd1);

        run_cmd("zw_write", 1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'h0);
        run_cmd("ws3_read", 1'b0, 32'h1000_0010, 32'h0, 4'hF, 3, 32'hCAFE_F00D);

        // Stray ack while idle.
        bad = 1'b0;
        bif.wbm_ack_i = 1'b1;
        repeat (3) begin
            step();
            if (bif.resp_valid || bif.wbm_cyc_o || state != ST_IDLE) bad = 1'b1;
        end
        bif.wbm_ack_i = 1'b0;
        chk("stray_idle", 64'(bad), 64'd0);

        // Back-to-back with req_valid held; stray ack held through RESP.
        exp_q.push_back(model_resp(1'b1, 0, 32'h0));
        d = $urandom;
        exp_q.push_back(model_resp(1'b0, 0, d));
        bif.req_valid = 1'b1;
        bif.req_we = 1'b1;
        bif.req_adr = 32'h0000_0100;
        bif.req_dat = 32'h1111_2222;
        bif.req_sel = 4'h3;
        step();
        chk("b2b A bus", {bif.wbm_cyc_o, bif.wbm_adr_o}, {1'b1, 32'h0000_0100});
        bif.req_we = 1'b0;
        bif.req_adr = 32'h0000_0200;
        bif.req_sel = 4'hC;
        bif.wbm_ack_i = 1'b1;
        step();
        exp = exp_q.pop_front();
        chk("b2b A resp", {bif.resp_valid, bif.resp_err, bif.resp_rdata}, {1'b1, exp});
        chk("b2b busy", {bif.req_ready, bif.wbm_cyc_o, bif.wbm_adr_o},
            {2'b00, 32'h0000_0100});
        step();
        bif.wbm_ack_i = 1'b0;
        chk("b2b idle", {bif.req_ready, bif.resp_valid, bif.wbm_cyc_o}, 64'b100);
        step();
        bif.req_valid = 1'b0;
        chk("b2b B bus", {bif.wbm_cyc_o, bif.wbm_we_o, bif.wbm_sel_o, bif.wbm_adr_o},
            {2'b10, 4'hC, 32'h0000_0200});
        bif.wbm_ack_i = 1'b1;
        bif.wbm_dat_i = d;
        step();
        bif.wbm_ack_i = 1'b0;
        exp = exp_q.pop_front();
        chk("b2b B resp", {bif.resp_valid, bif.resp_err, bif.resp_rdata}, {1'b1, exp});
        step();

        // Reset in the second bus cycle.
        bif.req_valid = 1'b1;
        bif.req_we = 1'b0;
        bif.req_adr = 32'h0000_0300;
        step();
        bif.req_valid = 1'b0;
        step();
        chk("rstbus pre", 64'(bif.wbm_cyc_o), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstbus drop", {bif.wbm_cyc_o, bif.wbm_stb_o, bif.resp_valid}, 64'd0);
        step();
        chk("rstbus after", {bif.req_ready, bif.resp_valid, bif.wbm_cyc_o}, 64'b100);

        if (TO_EN) begin
            run_cmd("to_silent", 1'b0, 32'h0000_0400, 32'h0, 4'hF, 1000, 32'h1234_5678);
            run_cmd("to_ack8", 1'b0, 32'h0000_0404, 32'h0, 4'hF, 7, 32'h8765_4321);
            run_cmd("to_ack9", 1'b1, 32'h0000_0408, 32'h5, 4'h1, 8, 32'h0);
        end else begin
            bad = 1'b0;
            bif.req_valid = 1'b1;
            bif.req_we = 1'b0;
            bif.req_adr = 32'h0000_0500;
            step();
            bif.req_valid = 1'b0;
            repeat (1000) begin
                if (!bif.wbm_cyc_o || bif.resp_valid || bif.resp_err) bad = 1'b1;
                step();
            end
            chk("silent_1000", 64'(bad), 64'd0);
            rst = 1'b1;
            step();
            rst = 1'b0;
            step();
        end

        for (int i = 0; i < 20; i++) begin
            run_cmd("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, TO_EN ? 12 : 5)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
